// File: rtl/pass_sched_pkg.sv
// pass_sched_pkg: shared state encoding and default widths for the layer pass scheduler.
package pass_sched_pkg;
   localparam int PS_ADDR_W = 32;
   localparam int PS_CH_W = 10;
   localparam int BYTES_PER_PSUM = 4;
   typedef enum logic [2:0] {IDLE, CHECK, LAUNCH, WAIT, NEXT, DONE} state_t;
endpackage

// File: rtl/pass_addr_gen.sv
// pass_addr_gen: per-pass base-address accumulators; c steps move ifmap, m steps move bias/opsum,
// and every pass step moves the filter pointer. All sums wrap modulo 2^ADDR_W.
module pass_addr_gen import pass_sched_pkg::*; #(
   parameter int ADDR_W = PS_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_i,
   input  logic              step_c_i,
   input  logic              step_m_i,
   input  logic              wrap_i,
   input  logic [ADDR_W-1:0] filter_base_i,
   input  logic [ADDR_W-1:0] ifmap_base_i,
   input  logic [ADDR_W-1:0] bias_base_i,
   input  logic [ADDR_W-1:0] opsum_base_i,
   input  logic [ADDR_W-1:0] filter_stride_i,
   input  logic [ADDR_W-1:0] ifmap_stride_i,
   input  logic [ADDR_W-1:0] opsum_stride_i,
   input  logic [ADDR_W-1:0] bias_stride_i,
   output logic [ADDR_W-1:0] filter_o,
   output logic [ADDR_W-1:0] ifmap_o,
   output logic [ADDR_W-1:0] bias_o,
   output logic [ADDR_W-1:0] opsum_o
);
   logic [ADDR_W-1:0] ifmap_base_q, fs_q, is_q, os_q, bs_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         {filter_o, ifmap_o, bias_o, opsum_o} <= '0;
         {ifmap_base_q, fs_q, is_q, os_q, bs_q} <= '0;
      end else if (init_i) begin
         filter_o <= filter_base_i;
         ifmap_o <= ifmap_base_i;
         bias_o <= bias_base_i;
         opsum_o <= opsum_base_i;
         ifmap_base_q <= ifmap_base_i;
         fs_q <= filter_stride_i;
         is_q <= ifmap_stride_i;
         os_q <= opsum_stride_i;
         bs_q <= bias_stride_i;
      end else begin
         if (step_c_i || step_m_i) filter_o <= filter_o + fs_q;
         if (wrap_i) ifmap_o <= ifmap_base_q;
         else if (step_c_i) ifmap_o <= ifmap_o + is_q;
         if (step_m_i) begin
            bias_o <= bias_o + bs_q;
            opsum_o <= opsum_o + os_q;
         end
      end
endmodule

// File: rtl/pass_scheduler.sv
// pass_scheduler: splits a conv layer into (m outer, c inner) passes and sequences the pass controller.
// Define PASS_SCHED_PERF_EN to add the perf_cycles/perf_passes counters.
module pass_scheduler import pass_sched_pkg::*; #(
   parameter int ADDR_W = PS_ADDR_W,
   parameter int CH_W = PS_CH_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CH_W-1:0]   layer_M,
   input  logic [CH_W-1:0]   layer_C,
   input  logic [2:0]        p,
   input  logic [2:0]        q,
   input  logic [2:0]        r,
   input  logic [2:0]        t,
   input  logic [ADDR_W-1:0] filter_base,
   input  logic [ADDR_W-1:0] ifmap_base,
   input  logic [ADDR_W-1:0] bias_base,
   input  logic [ADDR_W-1:0] opsum_base,
   input  logic [ADDR_W-1:0] filter_stride,
   input  logic [ADDR_W-1:0] ifmap_stride,
   input  logic [ADDR_W-1:0] opsum_stride,
   output logic              pass_start,
   input  logic              pass_done,
   output logic              bias_ipsum_sel,
   output logic [ADDR_W-1:0] filter_baseaddr,
   output logic [ADDR_W-1:0] ifmap_baseaddr,
   output logic [ADDR_W-1:0] bias_baseaddr,
   output logic [ADDR_W-1:0] opsum_baseaddr,
   output logic              busy,
   output logic              layer_done,
   output logic              cfg_err
`ifdef PASS_SCHED_PERF_EN
   ,
   output logic [31:0]       perf_cycles,
   output logic [15:0]       perf_passes
`endif
);
   state_t state_q;
   logic [CH_W-1:0] c_q, m_rem_q, c_rem_q;
   logic [5:0] pt_q, qr_q, pt_d, qr_d;
   logic init, last_c, last_m, step_c, step_m;
   assign pt_d = {3'b0, p} * {3'b0, t};
   assign qr_d = {3'b0, q} * {3'b0, r};
   assign init = state_q == IDLE && start;
   // Group counting by subtraction: the last group is the one whose remainder fits in one pass.
   assign last_c = c_rem_q <= CH_W'(qr_q);
   assign last_m = m_rem_q <= CH_W'(pt_q);
   assign step_c = state_q == NEXT && !last_c;
   assign step_m = state_q == NEXT && last_c && !last_m;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         {c_q, m_rem_q, c_rem_q, pt_q, qr_q} <= '0;
         {pass_start, bias_ipsum_sel, busy, layer_done, cfg_err} <= '0;
      end else begin
         pass_start <= 1'b0;
         layer_done <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               state_q <= CHECK;
               c_q <= layer_C;
               m_rem_q <= layer_M;
               c_rem_q <= layer_C;
               pt_q <= pt_d;
               qr_q <= qr_d;
               bias_ipsum_sel <= 1'b1;
               busy <= 1'b1;
               cfg_err <= 1'b0;
            end
            CHECK: begin
               if (m_rem_q == '0 || c_rem_q == '0 || pt_q == '0 || qr_q == '0) begin
                  state_q <= DONE;
                  cfg_err <= 1'b1;
                  layer_done <= 1'b1;
               end else begin
                  state_q <= LAUNCH;
                  pass_start <= 1'b1;
               end
            end
            LAUNCH: state_q <= WAIT;
            WAIT: if (pass_done) state_q <= NEXT;
            NEXT: begin
               if (last_c && last_m) begin
                  state_q <= DONE;
                  layer_done <= 1'b1;
               end else begin
                  state_q <= LAUNCH;
                  pass_start <= 1'b1;
               end
               c_rem_q <= last_c ? c_q : c_rem_q - CH_W'(qr_q);
               if (step_m) m_rem_q <= m_rem_q - CH_W'(pt_q);
               bias_ipsum_sel <= last_c;
            end
            DONE: begin
               state_q <= IDLE;
               busy <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   pass_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
      .clk(clk),
      .rst(rst),
      .init_i(init),
      .step_c_i(step_c),
      .step_m_i(step_m),
      .wrap_i(step_m),
      .filter_base_i(filter_base),
      .ifmap_base_i(ifmap_base),
      .bias_base_i(bias_base),
      .opsum_base_i(opsum_base),
      .filter_stride_i(filter_stride),
      .ifmap_stride_i(ifmap_stride),
      .opsum_stride_i(opsum_stride),
      .bias_stride_i(ADDR_W'(pt_d) * ADDR_W'(BYTES_PER_PSUM)),
      .filter_o(filter_baseaddr),
      .ifmap_o(ifmap_baseaddr),
      .bias_o(bias_baseaddr),
      .opsum_o(opsum_baseaddr)
   );
`ifdef PASS_SCHED_PERF_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         perf_cycles <= '0;
         perf_passes <= '0;
      end else if (init) begin
         perf_cycles <= '0;
         perf_passes <= '0;
      end else begin
         if (state_q != IDLE && !(&perf_cycles)) perf_cycles <= perf_cycles + 32'd1;
         if (state_q == WAIT && pass_done && !(&perf_passes)) perf_passes <= perf_passes + 16'd1;
      end
`endif
endmodule

// File: tb/tb_pass_scheduler.sv
// tb_pass_scheduler: table-driven layer runs with an index-based address model, plus reset/ignore corner cases.
module tb_pass_scheduler;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, pass_done = 1'b0;
   logic [9:0] layer_M = '0, layer_C = '0;
   logic [2:0] p = '0, q = '0, r = '0, t = '0;
   logic [31:0] filter_base = '0, ifmap_base = '0, bias_base = '0, opsum_base = '0;
   logic [31:0] filter_stride = '0, ifmap_stride = '0, opsum_stride = '0;
   logic pass_start, bias_ipsum_sel, busy, layer_done, cfg_err;
   logic [31:0] filter_baseaddr, ifmap_baseaddr, bias_baseaddr, opsum_baseaddr;
   int checks = 0, errors = 0;

   typedef struct {
      int unsigned m, c, p, q, r, t;
      logic [31:0] fb, ib, bb, ob, fs, ist, os;
      int n_m, n_c;
      bit err, inj;
   } vec_t;
   vec_t vecs[7];

   pass_scheduler dut (
      .clk(clk), .rst(rst), .start(start), .layer_M(layer_M), .layer_C(layer_C),
      .p(p), .q(q), .r(r), .t(t),
      .filter_base(filter_base), .ifmap_base(ifmap_base), .bias_base(bias_base), .opsum_base(opsum_base),
      .filter_stride(filter_stride), .ifmap_stride(ifmap_stride), .opsum_stride(opsum_stride),
      .pass_start(pass_start), .pass_done(pass_done), .bias_ipsum_sel(bias_ipsum_sel),
      .filter_baseaddr(filter_baseaddr), .ifmap_baseaddr(ifmap_baseaddr),
      .bias_baseaddr(bias_baseaddr), .opsum_baseaddr(opsum_baseaddr),
      .busy(busy), .layer_done(layer_done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // which=0 waits for pass_start, which=1 for layer_done; stray counts pass_starts seen while waiting for done
   task automatic wait_for(input bit which, output int cyc, output int stray);
      cyc = 0;
      stray = 0;
      while (!(which ? layer_done : pass_start) && cyc < 20) begin
         tick();
         cyc++;
         if (which && pass_start) stray++;
      end
   endtask

   task automatic run_layer(input vec_t v);
      int cyc, stray, mi, ci;
      layer_M = 10'(v.m); layer_C = 10'(v.c);
      p = 3'(v.p); q = 3'(v.q); r = 3'(v.r); t = 3'(v.t);
      filter_base = v.fb; ifmap_base = v.ib; bias_base = v.bb; opsum_base = v.ob;
      filter_stride = v.fs; ifmap_stride = v.ist; opsum_stride = v.os;
      start = 1'b1;
      tick();
      start = 1'b0;
      layer_M = 10'($urandom); layer_C = 10'($urandom);
      p = 3'($urandom); q = 3'($urandom); r = 3'($urandom); t = 3'($urandom);
      filter_base = $urandom; ifmap_base = $urandom; bias_base = $urandom; opsum_base = $urandom;
      filter_stride = $urandom; ifmap_stride = $urandom; opsum_stride = $urandom;
      chk("busy_after_start", {31'b0, busy}, 1);
      chk("cfg_err_cleared", {31'b0, cfg_err}, 0);
      if (!v.err) begin
         for (int k = 0; k < v.n_m * v.n_c; k++) begin
            wait_for(1'b0, cyc, stray);
            chk("launch_latency", cyc, 1);
            mi = k / v.n_c;
            ci = k % v.n_c;
            chk("filter_addr", filter_baseaddr, v.fb + 32'(k) * v.fs);
            chk("ifmap_addr", ifmap_baseaddr, v.ib + 32'(ci) * v.ist);
            chk("bias_addr", bias_baseaddr, v.bb + 32'(mi * int'(v.p * v.t) * 4));
            chk("opsum_addr", opsum_baseaddr, v.ob + 32'(mi) * v.os);
            chk("bias_ipsum_sel", {31'b0, bias_ipsum_sel}, {31'b0, ci == 0});
            if (v.inj) begin
               pass_done = 1'b1;
               start = 1'b1;
            end
            tick();
            pass_done = 1'b0;
            chk("pass_start_single", {31'b0, pass_start}, 0);
            if (v.inj) begin
               tick();
               start = 1'b0;
               chk("ignored_in_wait", {31'b0, pass_start}, 0);
            end
            tick();
            pass_done = 1'b1;
            tick();
            pass_done = 1'b0;
         end
      end
      wait_for(1'b1, cyc, stray);
      chk("done_latency", cyc, 1);
      chk("no_extra_pass", stray, 0);
      chk("busy_in_done", {31'b0, busy}, 1);
      chk("cfg_err_at_done", {31'b0, cfg_err}, {31'b0, v.err});
      tick();
      chk("busy_after_done", {31'b0, busy}, 0);
      chk("done_single", {31'b0, layer_done}, 0);
      chk("cfg_err_sticky", {31'b0, cfg_err}, {31'b0, v.err});
      tick();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_outs"}, {26'b0, pass_start, bias_ipsum_sel, busy, layer_done, cfg_err, 1'b0}, 0);
      chk({tag, "_filter"}, filter_baseaddr, 0);
      chk({tag, "_ifmap"}, ifmap_baseaddr, 0);
      chk({tag, "_bias"}, bias_baseaddr, 0);
      chk({tag, "_opsum"}, opsum_baseaddr, 0);
   endtask

   initial begin
      int cyc, stray;
      vecs[0] = '{8, 4, 2, 2, 2, 2, 32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h100, 32'h40, 32'h80, 2, 1, 0, 0};
      vecs[1] = '{4, 12, 2, 2, 2, 2, 32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h100, 32'h40, 32'h80, 1, 3, 0, 0};
      vecs[2] = '{5, 1, 2, 1, 1, 2, 32'h0, 32'h10, 32'h20, 32'h30, 32'h8, 32'h4, 32'hC, 2, 1, 0, 0};
      vecs[3] = '{8, 4, 0, 2, 2, 2, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 0, 0, 1, 0};
      vecs[4] = '{6, 5, 1, 1, 2, 3, 32'hA000, 32'hB000, 32'hC000, 32'hD000, 32'h24, 32'h18, 32'h30, 2, 3, 0, 1};
      vecs[5] = '{0, 4, 2, 2, 2, 2, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 0, 0, 1, 0};
      vecs[6] = '{3, 3, 1, 1, 1, 1, 32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hFFFF_FF00, 32'h10, 32'h8, 32'h80, 3, 3, 0, 0};
      tick();
      tick();
      chk_zero("reset");
      rst = 1'b0;
      tick();
      for (int i = 0; i < 7; i++) run_layer(vecs[i]);
      // Reset while a pass is outstanding abandons the layer silently.
      layer_M = 10'd8; layer_C = 10'd4; p = 3'd2; q = 3'd2; r = 3'd2; t = 3'd2;
      filter_base = 32'h55; ifmap_base = 32'h66; bias_base = 32'h77; opsum_base = 32'h88;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_for(1'b0, cyc, stray);
      chk("rst_seq_launch", cyc, 1);
      tick();
      rst = 1'b1;
      #1;
      chk_zero("mid_rst");
      tick();
      rst = 1'b0;
      pass_done = 1'b1;
      tick();
      pass_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("no_done_after_rst", {30'b0, layer_done, pass_start}, 0);
      end
      run_layer(vecs[0]);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
